// File: rtl/fifo_8x32_pkg.sv
// ---------------------------------------------------------------------------
// fifo_8x32_pkg
// Shared constants for the 8 x 32-bit FIFO: controller state encodings,
// storage depth and the width of the occupancy counter.
// No ports (package).
// ---------------------------------------------------------------------------
package fifo_8x32_pkg;

  localparam int DEPTH = 8;
  localparam int CNT_W = 4;   // holds 0..DEPTH inclusive

  typedef logic [2:0] state_t;

  // State reflects the operation decided at the previous clock edge.
  localparam state_t ST_INIT     = 3'd0;
  localparam state_t ST_NO_OP    = 3'd1;
  localparam state_t ST_WRITE    = 3'd2;
  localparam state_t ST_WR_ERROR = 3'd3;
  localparam state_t ST_READ     = 3'd4;
  localparam state_t ST_RD_ERROR = 3'd5;
  localparam state_t ST_WR_RD    = 3'd6;

endpackage

// File: rtl/fifo_8x32_ctrl.sv
// ---------------------------------------------------------------------------
// fifo_8x32_ctrl
// Combinational control for the FIFO: decides which operation takes place
// this cycle from (wr_en, rd_en, count) and produces next state, next
// head/tail pointers, next count and the write/read strobes.
// Ports:
//   i_wr_en, i_rd_en : requests for this cycle
//   i_count          : current occupancy 0..8
//   i_head, i_tail   : current read / write pointers
//   o_state_nxt      : operation decided this cycle (registered by top)
//   o_wr_do, o_rd_do : write / read actually performed this cycle
//   o_head_nxt, o_tail_nxt, o_count_nxt : next pointer / count values
// ---------------------------------------------------------------------------
module fifo_8x32_ctrl
  import fifo_8x32_pkg::*;
#(
  parameter int ADDR_WIDTH = 3
) (
  input  logic                  i_wr_en,
  input  logic                  i_rd_en,
  input  logic [CNT_W-1:0]      i_count,
  input  logic [ADDR_WIDTH-1:0] i_head,
  input  logic [ADDR_WIDTH-1:0] i_tail,
  output state_t                o_state_nxt,
  output logic                  o_wr_do,
  output logic                  o_rd_do,
  output logic [ADDR_WIDTH-1:0] o_head_nxt,
  output logic [ADDR_WIDTH-1:0] o_tail_nxt,
  output logic [CNT_W-1:0]      o_count_nxt
);

  logic w_full;
  logic w_empty;

  assign w_full  = (i_count == CNT_W'(DEPTH));
  assign w_empty = (i_count == '0);

  always_comb begin
    o_state_nxt = ST_NO_OP;
    o_wr_do     = 1'b0;
    o_rd_do     = 1'b0;
    unique case ({i_wr_en, i_rd_en})
      2'b10: begin
        if (!w_full) begin
          o_state_nxt = ST_WRITE;
          o_wr_do     = 1'b1;
        end else begin
          o_state_nxt = ST_WR_ERROR;
        end
      end
      2'b01: begin
        if (!w_empty) begin
          o_state_nxt = ST_READ;
          o_rd_do     = 1'b1;
        end else begin
          o_state_nxt = ST_RD_ERROR;
        end
      end
      2'b11: begin
        // Simultaneous request: the side that cannot proceed is dropped
        // silently rather than flagged, so the other side still completes.
        if (w_empty) begin
          o_state_nxt = ST_WRITE;
          o_wr_do     = 1'b1;
        end else if (w_full) begin
          o_state_nxt = ST_READ;
          o_rd_do     = 1'b1;
        end else begin
          o_state_nxt = ST_WR_RD;
          o_wr_do     = 1'b1;
          o_rd_do     = 1'b1;
        end
      end
      default: o_state_nxt = ST_NO_OP;
    endcase
  end

  // Pointers wrap naturally at the 3-bit boundary.
  assign o_head_nxt = o_rd_do ? i_head + 1'b1 : i_head;
  assign o_tail_nxt = o_wr_do ? i_tail + 1'b1 : i_tail;

  always_comb begin
    o_count_nxt = i_count;
    unique case ({o_wr_do, o_rd_do})
      2'b10:   o_count_nxt = i_count + 4'd1;
      2'b01:   o_count_nxt = i_count - 4'd1;
      default: o_count_nxt = i_count;
    endcase
  end

endmodule

// File: rtl/fifo_8x32.sv
// ---------------------------------------------------------------------------
// fifo_8x32
// Synchronous 8-entry x 32-bit FIFO between a bus-side producer and the
// datapath consumer. Registered read port, full/empty from the occupancy
// count, registered per-request ack/err status decoded from the state.
// Optional macro: FIFO_ALMOST_FLAGS_EN adds almost_full / almost_empty.
// Ports:
//   clk, reset_n      : clock (rising edge), asynchronous active-low reset
//   wr_en, din        : write request and data
//   rd_en, dout       : read request and registered read data
//   data_count        : stored words 0..8
//   full, empty       : count==8 / count==0
//   wr_ack, wr_err    : previous-cycle write accepted / rejected
//   rd_ack, rd_err    : previous-cycle read accepted / rejected
//   almost_full/empty : count==7 / count==1 (FIFO_ALMOST_FLAGS_EN only)
// ---------------------------------------------------------------------------
module fifo_8x32
  import fifo_8x32_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 3
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  wr_en,
  input  logic                  rd_en,
  input  logic [DATA_WIDTH-1:0] din,
  output logic [DATA_WIDTH-1:0] dout,
  output logic [CNT_W-1:0]      data_count,
  output logic                  full,
  output logic                  empty,
  output logic                  wr_ack,
  output logic                  wr_err,
  output logic                  rd_ack,
  output logic                  rd_err
`ifdef FIFO_ALMOST_FLAGS_EN
  ,
  output logic                  almost_full,
  output logic                  almost_empty
`endif
);

  state_t                r_state;
  logic [ADDR_WIDTH-1:0] r_head;
  logic [ADDR_WIDTH-1:0] r_tail;
  logic [CNT_W-1:0]      r_count;
  logic [DATA_WIDTH-1:0] r_dout;
  logic [DATA_WIDTH-1:0] r_mem [DEPTH];

  state_t                w_state_nxt;
  logic                  w_wr_do;
  logic                  w_rd_do;
  logic [ADDR_WIDTH-1:0] w_head_nxt;
  logic [ADDR_WIDTH-1:0] w_tail_nxt;
  logic [CNT_W-1:0]      w_count_nxt;
  logic [DEPTH-1:0]      w_wr_sel;
  logic [DATA_WIDTH-1:0] w_rd_word;

  fifo_8x32_ctrl #(
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_ctrl (
    .i_wr_en     (wr_en),
    .i_rd_en     (rd_en),
    .i_count     (r_count),
    .i_head      (r_head),
    .i_tail      (r_tail),
    .o_state_nxt (w_state_nxt),
    .o_wr_do     (w_wr_do),
    .o_rd_do     (w_rd_do),
    .o_head_nxt  (w_head_nxt),
    .o_tail_nxt  (w_tail_nxt),
    .o_count_nxt (w_count_nxt)
  );

  // State register, pointers, count and read data.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= ST_INIT;
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
      r_dout  <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_head  <= w_head_nxt;
      r_tail  <= w_tail_nxt;
      r_count <= w_count_nxt;
      if (w_rd_do) begin
        r_dout <= w_rd_word;
      end
    end
  end

  // One-hot write select from the 3:8 tail decode.
  always_comb begin
    w_wr_sel = '0;
    if (w_wr_do) begin
      w_wr_sel[r_tail] = 1'b1;
    end
  end

  for (genvar g = 0; g < DEPTH; g++) begin : g_mem
    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        r_mem[g] <= '0;
      end else if (w_wr_sel[g]) begin
        r_mem[g] <= din;
      end
    end
  end

  // 8:1 read mux. Reads the entry at head before this edge's write lands,
  // so a simultaneous op at count==1 returns the old word.
  assign w_rd_word = r_mem[r_head];

  // Output decode from state.
  always_comb begin
    wr_ack = 1'b0;
    wr_err = 1'b0;
    rd_ack = 1'b0;
    rd_err = 1'b0;
    unique case (r_state)
      ST_WRITE:    wr_ack = 1'b1;
      ST_WR_ERROR: wr_err = 1'b1;
      ST_READ:     rd_ack = 1'b1;
      ST_RD_ERROR: rd_err = 1'b1;
      ST_WR_RD: begin
        wr_ack = 1'b1;
        rd_ack = 1'b1;
      end
      default: ;
    endcase
  end

  assign dout       = r_dout;
  assign data_count = r_count;
  assign full       = (r_count == CNT_W'(DEPTH));
  assign empty      = (r_count == '0);

`ifdef FIFO_ALMOST_FLAGS_EN
  assign almost_full  = (r_count == CNT_W'(DEPTH - 1));
  assign almost_empty = (r_count == 4'd1);
`endif

endmodule
